banco_reg_param: RTL and testbench



---
 rtl/banco_reg_pkg.sv | 20 ++
 rtl/banco_reg_param_if.sv | 49 ++++
 rtl/banco_reg_param_rdport.sv | 40 ++++
 rtl/banco_reg_param.sv | 123 ++++++++++++
 tb/tb_banco_reg_param.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/banco_reg_pkg.sv
// ---------------------------------------------------------------------------
// banco_reg_pkg
// Shared types and default sizing for the parametrised register bank.
//   br_state_e : clear engine state (idle / sequential bulk clear)
//   BR_DATA_W  : default register width
//   BR_DEPTH   : default number of registers
//   BR_NUM_RD  : default number of read ports
// ---------------------------------------------------------------------------
package banco_reg_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } br_state_e;

    localparam int BR_DATA_W = 32;
    localparam int BR_DEPTH  = 32;
    localparam int BR_NUM_RD = 2;

endpackage : banco_reg_pkg

// File: rtl/banco_reg_param_if.sv
// ---------------------------------------------------------------------------
// banco_reg_param_if
// Bus bundle between the pipeline (decode/writeback) and the register bank.
//   we, waddr, wdata : write port (from writeback)
//   raddr            : packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rdata            : packed read data, port k at [k*DATA_W +: DATA_W]
//   clr_req          : single-cycle bulk clear request
//   busy             : bulk clear in progress
// Modports: master drives requests, slave is the register bank.
// ---------------------------------------------------------------------------
interface banco_reg_param_if
    import banco_reg_pkg::*;
#(
    parameter int DATA_W = BR_DATA_W,
    parameter int DEPTH  = BR_DEPTH,
    parameter int NUM_RD = BR_NUM_RD
) ();

    localparam int ADDR_W = $clog2(DEPTH);

    logic                       we;
    logic [ADDR_W-1:0]          waddr;
    logic [DATA_W-1:0]          wdata;
    logic [NUM_RD*ADDR_W-1:0]   raddr;
    logic [NUM_RD*DATA_W-1:0]   rdata;
    logic                       clr_req;
    logic                       busy;

    modport master (
        output we,
        output waddr,
        output wdata,
        output raddr,
        output clr_req,
        input  rdata,
        input  busy
    );

    modport slave (
        input  we,
        input  waddr,
        input  wdata,
        input  raddr,
        input  clr_req,
        output rdata,
        output busy
    );

endinterface : banco_reg_param_if

// File: rtl/banco_reg_param_rdport.sv
// ---------------------------------------------------------------------------
// banco_reg_rdport
// One combinational read port of the register bank. Selects, in priority:
// hardwired zero for register 0, same-cycle write forwarding, array content.
//   i_raddr  : read address of this port
//   i_waddr  : current write address
//   i_wdata  : current write data
//   i_byp_en : write is live this cycle and forwarding is allowed
//   i_mem_rd : array entry at i_raddr
//   o_rdata  : read result
// ---------------------------------------------------------------------------
module banco_reg_rdport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0] i_raddr,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_byp_en,
    input  logic [DATA_W-1:0] i_mem_rd,
    output logic [DATA_W-1:0] o_rdata
);

    logic w_is_zero;
    logic w_hit;

    assign w_is_zero = (ZERO_REG != 0) && (i_raddr == '0);
    assign w_hit     = i_byp_en && (i_raddr == i_waddr);

    always_comb begin
        o_rdata = i_mem_rd;
        if (w_is_zero) begin
            o_rdata = '0;
        end else if (w_hit) begin
            o_rdata = i_wdata;
        end
    end

endmodule : banco_reg_rdport

// File: rtl/banco_reg_param.sv
// ---------------------------------------------------------------------------
// banco_reg_param
// Parametrised register bank: one clocked write port, NUM_RD combinational
// read ports, optional write-to-read forwarding, optional hardwired register
// 0, and a sequential bulk-clear engine that zeroes one entry per cycle.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset (clears state and array)
//   bus.we/waddr/wdata : write port, ignored while a clear runs
//   bus.raddr  : packed read addresses
//   bus.rdata  : packed read data
//   bus.clr_req: starts a bulk clear from idle
//   bus.busy   : high while the clear engine runs (DEPTH cycles)
// ---------------------------------------------------------------------------
module banco_reg_param
    import banco_reg_pkg::*;
#(
    parameter int DATA_W   = BR_DATA_W,
    parameter int DEPTH    = BR_DEPTH,
    parameter int NUM_RD   = BR_NUM_RD,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    banco_reg_param_if.slave  bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    // Storage and clear engine state
    logic [DATA_W-1:0] r_mem [DEPTH];
    br_state_e         r_state;
    logic [ADDR_W-1:0] r_clr_idx;

    // Write qualification
    logic w_idle;
    logic w_wr_en;
    logic w_byp_en;

    assign w_idle  = (r_state == ST_IDLE);

    // Register 0 is never written when it is hardwired, so the array entry
    // stays 0 and the read mux does not need to rely on it.
    assign w_wr_en = bus.we && w_idle &&
                     !((ZERO_REG != 0) && (bus.waddr == '0));

    // Forwarding is only meaningful when the write will actually commit;
    // during a clear the array is returned unmodified.
    assign w_byp_en = (BYPASS != 0) && bus.we && w_idle;

    assign bus.busy = (r_state == ST_CLEAR);

    // Array, write port and clear FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_clr_idx <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A write in the same cycle as clr_req still commits;
                    // the clear sweep overwrites it later.
                    if (w_wr_en) begin
                        r_mem[bus.waddr] <= bus.wdata;
                    end
                    if (bus.clr_req) begin
                        r_state   <= ST_CLEAR;
                        r_clr_idx <= '0;
                    end
                end
                ST_CLEAR: begin
                    // clr_req is ignored here: no restart, no extension.
                    r_mem[r_clr_idx] <= '0;
                    r_clr_idx        <= r_clr_idx + ADDR_W'(1);
                    if (r_clr_idx == LAST_IDX) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read ports
    logic [ADDR_W-1:0]        w_raddr  [NUM_RD];
    logic [DATA_W-1:0]        w_arr_rd [NUM_RD];
    logic [DATA_W-1:0]        w_rd     [NUM_RD];
    logic [NUM_RD*DATA_W-1:0] w_rdata_flat;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        assign w_raddr[k]  = bus.raddr[k*ADDR_W +: ADDR_W];
        assign w_arr_rd[k] = r_mem[w_raddr[k]];

        banco_reg_rdport #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rdport (
            .i_raddr  (w_raddr[k]),
            .i_waddr  (bus.waddr),
            .i_wdata  (bus.wdata),
            .i_byp_en (w_byp_en),
            .i_mem_rd (w_arr_rd[k]),
            .o_rdata  (w_rd[k])
        );
    end

    always_comb begin
        w_rdata_flat = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            w_rdata_flat[k*DATA_W +: DATA_W] = w_rd[k];
        end
    end

    assign bus.rdata = w_rdata_flat;

endmodule : banco_reg_param

// File: tb/tb_banco_reg_param.sv
// ---------------------------------------------------------------------------
// tb_banco_reg_param
// Directed scoreboard bench for banco_reg_param. Two banks share stimulus:
// dut_a with forwarding, dut_b without. Stimulus pushes expected values into
// a queue; a negedge monitor pops and compares against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_banco_reg_param;

    localparam int DW = 32;
    localparam int DP = 32;
    localparam int NR = 2;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Shared stimulus
    logic          t_we;
    logic [AW-1:0] t_waddr;
    logic [DW-1:0] t_wdata;
    logic [AW-1:0] t_ra0;
    logic [AW-1:0] t_ra1;
    logic          t_clr;

    banco_reg_param_if #(.DATA_W(DW), .DEPTH(DP), .NUM_RD(NR)) ifa ();
    banco_reg_param_if #(.DATA_W(DW), .DEPTH(DP), .NUM_RD(NR)) ifb ();

    assign ifa.we      = t_we;
    assign ifa.waddr   = t_waddr;
    assign ifa.wdata   = t_wdata;
    assign ifa.raddr   = {t_ra1, t_ra0};
    assign ifa.clr_req = t_clr;
    assign ifb.we      = t_we;
    assign ifb.waddr   = t_waddr;
    assign ifb.wdata   = t_wdata;
    assign ifb.raddr   = {t_ra1, t_ra0};
    assign ifb.clr_req = t_clr;

    banco_reg_param #(
        .DATA_W(DW), .DEPTH(DP), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    banco_reg_param #(
        .DATA_W(DW), .DEPTH(DP), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    // Scoreboard
    // kind: 0/1 = dut_a lane0/1, 2/3 = dut_b lane0/1, 4 = dut_a busy,
    //       5 = bench-measured quantity carried in q_obs
    int          q_kind [$];
    logic [31:0] q_exp  [$];
    string       q_name [$];
    logic [31:0] q_obs  [$];

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model [DP];

    task automatic push(input int kind, input logic [31:0] exp, input string name);
        q_kind.push_back(kind);
        q_exp.push_back(exp);
        q_name.push_back(name);
    endtask

    always @(negedge clk) begin
        int          k;
        logic [31:0] e;
        logic [31:0] act;
        string       nm;
        while (q_kind.size() > 0) begin
            k  = q_kind.pop_front();
            e  = q_exp.pop_front();
            nm = q_name.pop_front();
            case (k)
                0: act = ifa.rdata[31:0];
                1: act = ifa.rdata[63:32];
                2: act = ifb.rdata[31:0];
                3: act = ifb.rdata[63:32];
                4: act = {31'b0, ifa.busy};
                5: act = (q_obs.size() > 0) ? q_obs.pop_front() : 32'hxxxx_xxxx;
                default: act = 32'hxxxx_xxxx;
            endcase
            n_tests++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", nm, act, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        t_we    = 1'b1;
        t_waddr = a;
        t_wdata = d;
        tick();
        t_we = 1'b0;
        if (a != '0) model[a] = d;
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < DP; a++) begin
            t_ra0 = AW'(a);
            t_ra1 = AW'(a);
            push(0, model[a], $sformatf("%s a_l0[%0d]", tag, a));
            push(1, model[a], $sformatf("%s a_l1[%0d]", tag, a));
            push(2, model[a], $sformatf("%s b_l0[%0d]", tag, a));
            tick();
        end
    endtask

    // Entered just after the edge that sampled clr_req. Counts busy cycles,
    // optionally re-pulses clr_req, and probes both lanes at one busy cycle.
    task automatic run_busy(input int reclr_at, input int probe_at,
                            input bit probe_wr,
                            input logic [AW-1:0] pa0, input logic [31:0] pe0,
                            input logic [AW-1:0] pa1, input logic [31:0] pe1,
                            input string tag);
        int cnt;
        cnt = 0;
        for (int c = 0; c < 40 && ifa.busy; c++) begin
            cnt++;
            t_clr = (cnt == reclr_at);
            t_we  = 1'b0;
            if (cnt == probe_at) begin
                t_ra0 = pa0;
                t_ra1 = pa1;
                if (probe_wr) begin
                    t_we    = 1'b1;
                    t_waddr = pa0;
                    t_wdata = 32'h0BAD_0BAD;
                end
                push(0, pe0, {tag, " probe lane0"});
                push(1, pe1, {tag, " probe lane1"});
            end
            tick();
        end
        t_clr = 1'b0;
        t_we  = 1'b0;
        q_obs.push_back(32'(cnt));
        push(5, 32'd32, {tag, " busy cycles"});
        push(4, 32'd0, {tag, " busy low after"});
        tick();
        for (int a = 0; a < DP; a++) model[a] = '0;
    endtask

    initial begin
        rst     = 1'b1;
        t_we    = 1'b0;
        t_waddr = '0;
        t_wdata = '0;
        t_ra0   = '0;
        t_ra1   = '0;
        t_clr   = 1'b0;
        for (int a = 0; a < DP; a++) model[a] = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        push(4, 32'd0, "reset busy");
        read_all("reset");

        // Write then read back next cycle
        wr(5, 32'hDEAD_BEEF);
        t_ra1 = 5;
        push(1, 32'hDEAD_BEEF, "readback r5");
        tick();

        // Register 0 hardwired, including same-cycle forwarding
        t_we = 1'b1; t_waddr = 0; t_wdata = 32'h0000_1234; t_ra0 = 0;
        push(0, 32'h0, "r0 during write");
        tick();
        t_we = 1'b0;
        push(0, 32'h0, "r0 after write");
        push(2, 32'h0, "r0 after write b");
        tick();

        // Forwarding vs no forwarding
        wr(7, 32'h0000_0011);
        t_we = 1'b1; t_waddr = 7; t_wdata = 32'hA5A5_A5A5; t_ra0 = 7;
        push(0, 32'hA5A5_A5A5, "bypass a");
        push(2, 32'h0000_0011, "no bypass b old");
        tick();
        t_we = 1'b0;
        model[7] = 32'hA5A5_A5A5;
        push(0, 32'hA5A5_A5A5, "after write a");
        push(2, 32'hA5A5_A5A5, "after write b");
        tick();

        // Bulk clear: fill with index, clear, dropped write at busy cycle 21
        for (int a = 1; a < DP; a++) wr(AW'(a), 32'(a));
        read_all("filled");
        t_clr = 1'b1;
        tick();
        t_clr = 1'b0;
        run_busy(0, 21, 1'b1, 5'd3, 32'h0, 5'd25, 32'd25, "clear1");
        read_all("cleared");

        // Overlap: clr_req with write to r9, re-request at busy cycle 11
        t_we = 1'b1; t_waddr = 9; t_wdata = 32'h0000_00FF; t_clr = 1'b1;
        tick();
        t_we = 1'b0; t_clr = 1'b0;
        run_busy(11, 5, 1'b0, 5'd9, 32'h0000_00FF, 5'd20, 32'h0, "clear2");
        t_ra1 = 9;
        push(1, 32'h0, "r9 after clear");
        tick();

        // Reset mid-clear
        wr(2, 32'h0000_0022);
        wr(30, 32'h0000_0030);
        t_clr = 1'b1;
        tick();
        t_clr = 1'b0;
        for (int c = 0; c < 4 && ifa.busy; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int a = 0; a < DP; a++) model[a] = '0;
        push(4, 32'd0, "busy after mid-clear rst");
        read_all("rst mid-clear");
        wr(2, 32'h1357_2468);
        t_ra1 = 2;
        push(1, 32'h1357_2468, "r2 after rst");
        push(4, 32'd0, "busy stays low");
        tick();

        tick();
        if (q_kind.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q_kind.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_banco_reg_param
